match_ctrl: RTL and testbench

//  Match-level controller downstream of the collision stage. Consumes the registered per-step

---
 rtl/snake_pkg.sv | 26 ++
 rtl/match_ctrl_sat_counter.sv | 21 ++
 rtl/match_ctrl.sv | 131 +++++++++++++
 tb/tb_match_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake game: display mode, match FSM states and winner codes.
package snake_pkg;

  typedef enum logic [1:0] {
    MENU = 2'd0,
    GAME = 2'd1,
    END  = 2'd2
  } game_mode;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PLAY  = 3'd2,
    S_EVAL  = 3'd3,
    S_PAUSE = 3'd4,
    S_END   = 3'd5
  } match_state_e;

  localparam int ROUND_W = 3;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/match_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over inc.
module sat_counter #(
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [SCORE_W-1:0] cnt
);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc)   cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/match_ctrl.sv
// Match-level controller: sequences rounds, tracks points and rounds won, decides the match.
module match_ctrl
  import snake_pkg::*;
#(
  parameter int ROUNDS_TO_WIN = 3,
  parameter int MAX_ROUNDS    = 5,
  parameter int WAIT_TICKS    = 4,
  parameter int SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               won,
  input  logic               lost,
  input  logic               draw,
  input  logic               eaten1,
  input  logic               eaten2,
  output game_mode           mode,
  output logic               map_reset,
  output logic               round_over,
  output logic               match_over,
  output logic [1:0]         winner,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [2:0]         rounds1,
  output logic [2:0]         rounds2,
  output logic [2:0]         pause_cnt
);

  match_state_e         state, state_next;
  logic [ROUND_W-1:0]   round_cnt;
  logic                 eaten1_q, eaten2_q;
  logic                 any_result;

  assign any_result = won | lost | draw;

  sat_counter #(.SCORE_W(SCORE_W)) u_score1 (
    .clk (clk),
    .rst (rst),
    .inc (state == S_PLAY && eaten1 && !eaten1_q),
    .clr (state == S_LOAD),
    .cnt (score1)
  );

  sat_counter #(.SCORE_W(SCORE_W)) u_score2 (
    .clk (clk),
    .rst (rst),
    .inc (state == S_PLAY && eaten2 && !eaten2_q),
    .clr (state == S_LOAD),
    .cnt (score2)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  state_next = S_PLAY;
      S_PLAY:  if (any_result) state_next = S_EVAL;
      S_EVAL:  if (rounds1 == ROUND_W'(ROUNDS_TO_WIN) || rounds2 == ROUND_W'(ROUNDS_TO_WIN) ||
                   round_cnt == ROUND_W'(MAX_ROUNDS))
                 state_next = S_END;
               else
                 state_next = S_PAUSE;
      S_PAUSE: if (pause_cnt == '0) state_next = S_LOAD;
      S_END:   if (start) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mode       <= MENU;
      map_reset  <= 1'b0;
      round_over <= 1'b0;
      match_over <= 1'b0;
      winner     <= WIN_NONE;
      rounds1    <= '0;
      rounds2    <= '0;
      round_cnt  <= '0;
      pause_cnt  <= '0;
      eaten1_q   <= 1'b0;
      eaten2_q   <= 1'b0;
    end else begin
      state      <= state_next;
      eaten1_q   <= eaten1;
      eaten2_q   <= eaten2;
      map_reset  <= (state_next == S_LOAD);
      round_over <= 1'b0;
      // LOAD keeps the previous mode so the menu stays up until play starts
      case (state_next)
        S_IDLE:  mode <= MENU;
        S_END:   mode <= END;
        S_LOAD:  mode <= mode;
        default: mode <= GAME;
      endcase
      case (state)
        S_IDLE: if (start) begin
          rounds1   <= '0;
          rounds2   <= '0;
          round_cnt <= '0;
        end
        S_PLAY: if (any_result) begin
          round_over <= 1'b1;
          round_cnt  <= round_cnt + ROUND_W'(1);
          if (draw)      ;
          else if (lost) rounds2 <= rounds2 + ROUND_W'(1);
          else           rounds1 <= rounds1 + ROUND_W'(1);
        end
        S_EVAL: begin
          if (rounds1 == ROUND_W'(ROUNDS_TO_WIN))      winner <= WIN_P1;
          else if (rounds2 == ROUND_W'(ROUNDS_TO_WIN)) winner <= WIN_P2;
          else if (round_cnt == ROUND_W'(MAX_ROUNDS))
            winner <= (rounds1 > rounds2) ? WIN_P1 :
                      (rounds2 > rounds1) ? WIN_P2 : WIN_DRAW;
          else
            pause_cnt <= 3'(WAIT_TICKS);
          match_over <= (state_next == S_END);
        end
        S_PAUSE: if (tick && pause_cnt != '0) pause_cnt <= pause_cnt - 3'd1;
        S_END: if (start) begin
          winner     <= WIN_NONE;
          match_over <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_match_ctrl.sv
// Scoreboard bench for match_ctrl: stimulus queues expected round/map/winner events, a monitor checks them.
module tb_match_ctrl;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       rst, tick, start, won, lost, draw, eaten1, eaten2;
  game_mode   mode;
  logic       map_reset, round_over, match_over;
  logic [1:0] winner;
  logic [7:0] score1, score2;
  logic [2:0] rounds1, rounds2, pause_cnt;

  typedef struct { int r1; int r2; int s1; int s2; } round_exp_t;
  round_exp_t round_q[$];
  int         map_q[$];
  int         win_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  logic match_over_prev = 1'b0;

  match_ctrl #(.ROUNDS_TO_WIN(3), .MAX_ROUNDS(5), .WAIT_TICKS(4), .SCORE_W(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .won(won), .lost(lost), .draw(draw),
    .eaten1(eaten1), .eaten2(eaten2), .mode(mode), .map_reset(map_reset),
    .round_over(round_over), .match_over(match_over), .winner(winner),
    .score1(score1), .score2(score2), .rounds1(rounds1), .rounds2(rounds2),
    .pause_cnt(pause_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output event must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (round_over) begin
        if (round_q.size() == 0) chk("unexpected_round_over", 1, 0);
        else begin
          round_exp_t e;
          e = round_q.pop_front();
          chk("round_rounds1", int'(rounds1), e.r1);
          chk("round_rounds2", int'(rounds2), e.r2);
          chk("round_score1", int'(score1), e.s1);
          chk("round_score2", int'(score2), e.s2);
        end
      end
      if (map_reset) begin
        if (map_q.size() == 0) chk("unexpected_map_reset", 1, 0);
        else chk("map_reset_rounds", int'(rounds1) * 8 + int'(rounds2), map_q.pop_front());
      end
      if (match_over && !match_over_prev) begin
        if (win_q.size() == 0) chk("unexpected_match_over", 1, 0);
        else chk("winner", int'(winner), win_q.pop_front());
      end
    end
    match_over_prev <= match_over;
  end

  // One round from PLAY: result held 'hold' clk, then either END or a full pause back into PLAY.
  task automatic round(input bit w, l, d, input int e1, e2, s1, s2, input int hold,
                       input bit fin, input int win);
    round_q.push_back('{e1, e2, s1, s2});
    if (fin) win_q.push_back(win);
    won = w; lost = l; draw = d;
    repeat (hold) step();
    won = 0; lost = 0; draw = 0; eaten1 = 0; eaten2 = 0;
    if (hold < 2) repeat (2 - hold) step();
    if (fin) begin
      chk("end_mode", int'(mode), int'(END));
      chk("end_match_over", int'(match_over), 1);
      return;
    end
    chk("pause_start_cnt", int'(pause_cnt), 4);
    chk("pause_mode", int'(mode), int'(GAME));
    for (int k = 3; k >= 0; k--) begin
      tick = 1; step(); tick = 0;
      chk("pause_countdown", int'(pause_cnt), k);
    end
    map_q.push_back(e1 * 8 + e2);
    step();
    step();
    chk("play_score1_cleared", int'(score1), 0);
    chk("play_score2_cleared", int'(score2), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; tick = 0; start = 0; won = 0; lost = 0; draw = 0; eaten1 = 0; eaten2 = 0;
    step(); step();
    rst = 0;
    chk("rst_mode", int'(mode), int'(MENU));
    chk("rst_map_reset", int'(map_reset), 0);
    chk("rst_rounds", int'(rounds1) + int'(rounds2), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_pause", int'(pause_cnt), 0);
    chk("rst_match_over", int'(match_over), 0);

    // start -> LOAD with map_reset, then PLAY
    start = 1; map_q.push_back(0);
    step(); start = 0;
    chk("load_map_reset", int'(map_reset), 1);
    chk("load_mode", int'(mode), int'(MENU));
    step();
    chk("play_mode", int'(mode), int'(GAME));
    chk("play_map_reset_low", int'(map_reset), 0);
    chk("play_score1", int'(score1), 0);

    // eaten1 held 5 clk twice; eaten2 rises together with the second eaten1
    eaten1 = 1; repeat (5) step(); eaten1 = 0; step();
    eaten1 = 1; eaten2 = 1; repeat (5) step(); eaten1 = 0; eaten2 = 0; step();
    chk("score1_two_edges", int'(score1), 2);
    chk("score2_same_clk", int'(score2), 1);
    for (int i = 0; i < 253; i++) begin
      eaten1 = 1; step(); eaten1 = 0; step();
    end
    chk("score1_reach_max", int'(score1), 255);
    eaten1 = 1; step(); step(); eaten1 = 0; step();
    chk("score1_saturated", int'(score1), 255);

    // won held 3 clk with an eaten2 edge in the same clk as the result
    eaten2 = 1;
    round(1, 0, 0, 1, 0, 255, 2, 3, 0, 0);

    // three P2 wins -> END, winner P2
    round(0, 1, 0, 1, 1, 0, 0, 1, 0, 0);
    round(0, 1, 0, 1, 2, 0, 0, 1, 0, 0);
    round(0, 1, 0, 1, 3, 0, 0, 1, 1, 2);
    tick = 1; won = 1; eaten1 = 1; step(); step(); tick = 0; won = 0; eaten1 = 0; step();
    chk("end_rounds1_frozen", int'(rounds1), 1);
    chk("end_rounds2_frozen", int'(rounds2), 3);
    chk("end_score1_frozen", int'(score1), 0);
    start = 1; step(); start = 0;
    chk("idle_mode", int'(mode), int'(MENU));
    chk("idle_winner", int'(winner), 0);
    chk("idle_match_over", int'(match_over), 0);

    // won+draw counts as draw; five draws reach the round cap with a tie
    start = 1; map_q.push_back(0); step(); start = 0; step();
    round(1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    round(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    round(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    round(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    round(0, 0, 1, 0, 0, 0, 0, 1, 1, 3);

    // won+lost counts as lost; then reset in the middle of the pause
    start = 1; step(); start = 0;
    start = 1; map_q.push_back(0); step(); start = 0; step();
    round_q.push_back('{0, 1, 0, 0});
    won = 1; lost = 1; step(); won = 0; lost = 0; step();
    chk("pause2_start", int'(pause_cnt), 4);
    repeat (2) begin tick = 1; step(); tick = 0; end
    chk("pause2_mid", int'(pause_cnt), 2);
    rst = 1; step(); rst = 0;
    chk("midrst_mode", int'(mode), int'(MENU));
    chk("midrst_pause", int'(pause_cnt), 0);
    chk("midrst_rounds2", int'(rounds2), 0);
    chk("midrst_map_reset", int'(map_reset), 0);
    repeat (6) begin tick = 1; step(); tick = 0; end
    chk("midrst_stays_menu", int'(mode), int'(MENU));

    chk("round_q_drained", round_q.size(), 0);
    chk("map_q_drained", map_q.size(), 0);
    chk("win_q_drained", win_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
